sdram_protocol_monitor: RTL and testbench
=========================================

// Module: sdram_protocol_monitor
// PURPOSE
//  Synthesizable, parametrised SDRAM/Wishbone protocol monitor on the SDRAM controller command bus.
//  Checks the power-up init sequence (NOP window, PRECHARGE, N x AUTO_REFRESH, LOAD_MODE_REG, init_done).
//  Checks CAS-latency read-data timing for any CL in 1..MAX_CAS.
//  Optionally checks Wishbone cyc/stb/ack rules. Reports sticky flags, first-error code and a saturating count.
// PARAMETERS
//  INIT_NOP_CYCLES    10000  min consecutive NOP/INHIBIT cycles after reset release
//  INIT_REFRESH_CNT   16     AUTO_REFRESH commands required before LOAD_MODE_REG
//  INIT_DONE_TIMEOUT  32     max cycles from LOAD_MODE_REG to sdr_init_done high
//  MAX_CAS            3      largest supported CAS latency (cfg_sdr_cas range 1..MAX_CAS)
//  WB_ACK_TIMEOUT     64     max cycles cyc&stb may wait for ack
//  ERR_CNT_W          8      width of err_count
// PORTS
//  sys_clk        in   1          sole clock, all logic on posedge
//  reset_n        in   1          synchronous, active-low reset
//  sdr_cs_n       in   1          SDRAM chip select
//  sdr_ras_n      in   1          SDRAM RAS
//  sdr_cas_n      in   1          SDRAM CAS
//  sdr_we_n       in   1          SDRAM WE
//  dataout_en     in   1          read data valid from SDRAM
//  cfg_sdr_cas    in   2          configured CAS latency
//  sdr_init_done  in   1          controller init complete
//  wb_cyc_i       in   1          Wishbone cycle
//  wb_stb_i       in   1          Wishbone strobe
//  wb_ack_i       in   1          Wishbone acknowledge
//  init_ok        out  1          init sequence passed (sticky)
//  err_init       out  1          init violation (sticky)
//  err_cas        out  1          CAS-latency violation (sticky)
//  err_wb         out  1          Wishbone violation (sticky; 0 when feature out)
//  err_code       out  3          first error: 0 none, 1 early cmd, 2 no PRE, 3 bad refresh/LMR, 4 done timeout, 5 CAS, 6 WB stb/ack, 7 WB timeout
//  err_count      out  ERR_CNT_W  total violations, saturates at all-ones
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): all outputs 0, FSM->S_NOP, counters/pipeline cleared.
//  - Decode (cs_n,ras_n,cas_n,we_n): INHIBIT 1xxx, NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100,
//    AUTO_REFRESH 0001, PRECHARGE 0010, LOAD_MODE_REG 0000.
//  - Init FSM, one transition per cycle:
//    S_NOP: count NOP/INHIBIT; other cmd with count<INIT_NOP_CYCLES -> S_FAIL code 1; count reached -> S_PRE.
//    S_PRE: NOP/INHIBIT stay; PRECHARGE -> S_REF; any other cmd -> S_FAIL code 2.
//    S_REF: count AUTO_REFRESH (saturate); NOP/INHIBIT stay; LOAD_MODE_REG with count>=INIT_REFRESH_CNT -> S_WDONE;
//      LMR early, or ACTIVE/READ/WRITE/PRECHARGE -> S_FAIL code 3.
//    S_WDONE: sdr_init_done=1 within INIT_DONE_TIMEOUT cycles -> S_DONE (init_ok=1 next cycle);
//      timeout -> S_FAIL code 4.
//    sdr_init_done=1 in any state before S_WDONE -> S_FAIL code 3.
//    S_DONE, S_FAIL terminal until reset; entry to S_FAIL sets err_init.
//  - CAS check (S_DONE only): shift register MAX_CAS+1 deep, bit0 set on READ.
//    Bit at tap cfg_sdr_cas set and dataout_en=0 that cycle -> err_cas, code 5.
//    Extra dataout_en (bursts) not flagged. cfg_sdr_cas 0 or >MAX_CAS disables check.
//    Any cfg_sdr_cas change flushes the pipeline and suppresses checks for MAX_CAS+1 cycles.
//  - Error bookkeeping: err_* sticky; err_code written only while 0; err_count +1 per violating cycle
//    (multiple same cycle count as 1). Flags and count update the cycle after detection.
//  - reset_n low mid-sequence aborts everything; monitoring restarts at S_NOP.
// CONFIGURATION
//  - SDRAM_MON_WB_CHECK_EN defined: Wishbone checks compiled in:
//    - stb without cyc -> code 6.
//    - ack while !(cyc&stb) -> code 6.
//    - cyc&stb held WB_ACK_TIMEOUT cycles without ack -> code 7.
//    - Wait counter clears on ack or on cyc drop.
//  - Not defined: Wishbone logic absent, err_wb tied 0, wb_* inputs unused.
// TESTING
//  - Reset, 10000 NOP, PRE, 16x(REF+9 NOP), LMR, init_done after 18 cyc -> init_ok=1, err_code=0, err_count=0.
//  - ACTIVE at NOP count 500 -> err_init=1, err_code=1, err_count=1, init_ok stays 0.
//  - Valid init, 15 REF then LMR -> err_code=3. Separately, init_done missing 32 cyc after LMR -> err_code=4.
//  - CL=3, READ with dataout_en at +3 -> no error; CL=2 with data at +3 -> err_cas=1, err_code=5.
//  - WB_CHECK_EN: cyc&stb held 64 cyc without ack -> err_wb=1, code 7; ack without stb -> code 6 if first.
//  - Violation, then reset_n=0 one cycle mid-REF, then clean init -> all flags 0, count 0, init_ok=1.

Source files
------------

// File: rtl/sdram_protocol_monitor.sv
// SDRAM controller command-bus monitor: init sequence, CAS read timing, Wishbone.
// Build option: define SDRAM_MON_WB_CHECK_EN to compile in the Wishbone checks.
module sdram_protocol_monitor #(
    parameter int INIT_NOP_CYCLES   = 10000,
    parameter int INIT_REFRESH_CNT  = 16,
    parameter int INIT_DONE_TIMEOUT = 32,
    parameter int MAX_CAS           = 3,
    parameter int WB_ACK_TIMEOUT    = 64,
    parameter int ERR_CNT_W         = 8
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 sdr_cs_n,
    input  logic                 sdr_ras_n,
    input  logic                 sdr_cas_n,
    input  logic                 sdr_we_n,
    input  logic                 dataout_en,
    input  logic [1:0]           cfg_sdr_cas,
    input  logic                 sdr_init_done,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_ack_i,
    output logic                 init_ok,
    output logic                 err_init,
    output logic                 err_cas,
    output logic                 err_wb,
    output logic [2:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int NOP_W  = $clog2(INIT_NOP_CYCLES + 1);
    localparam int REF_W  = $clog2(INIT_REFRESH_CNT + 1);
    localparam int DONE_W = $clog2(INIT_DONE_TIMEOUT + 1);
    localparam int SUP_W  = $clog2(MAX_CAS + 2);

    typedef enum logic [2:0] {
        S_NOP, S_PRE, S_REF, S_WDONE, S_DONE, S_FAIL
    } state_t;

    state_t            state;
    logic [NOP_W-1:0]  nop_cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic [DONE_W-1:0] done_cnt;

    logic is_nop, is_pre, is_ref, is_lmr, is_read;
    logic ref_full;
    logic init_fail;
    logic [2:0] init_code;

    // command decode; INHIBIT (cs_n high) counts as a NOP
    always_comb begin
        is_nop  = sdr_cs_n | ({sdr_ras_n, sdr_cas_n, sdr_we_n} == 3'b111);
        is_pre  = !sdr_cs_n & ({sdr_ras_n, sdr_cas_n, sdr_we_n} == 3'b010);
        is_ref  = !sdr_cs_n & ({sdr_ras_n, sdr_cas_n, sdr_we_n} == 3'b001);
        is_lmr  = !sdr_cs_n & ({sdr_ras_n, sdr_cas_n, sdr_we_n} == 3'b000);
        is_read = !sdr_cs_n & ({sdr_ras_n, sdr_cas_n, sdr_we_n} == 3'b101);
    end

    assign ref_full = ref_cnt >= REF_W'(INIT_REFRESH_CNT);

    // init-sequence violation detection for the current state and command
    always_comb begin
        init_fail = 1'b0;
        init_code = 3'd0;
        unique case (state)
            S_NOP: begin
                if (sdr_init_done) begin
                    init_fail = 1'b1;
                    init_code = 3'd3;
                end else if (!is_nop) begin
                    init_fail = 1'b1;
                    init_code = 3'd1;
                end
            end
            S_PRE: begin
                if (sdr_init_done) begin
                    init_fail = 1'b1;
                    init_code = 3'd3;
                end else if (!is_nop && !is_pre) begin
                    init_fail = 1'b1;
                    init_code = 3'd2;
                end
            end
            S_REF: begin
                if (sdr_init_done ||
                    (is_lmr && !ref_full) ||
                    !(is_nop || is_ref || is_lmr)) begin
                    init_fail = 1'b1;
                    init_code = 3'd3;
                end
            end
            S_WDONE: begin
                if (!sdr_init_done &&
                    done_cnt == DONE_W'(INIT_DONE_TIMEOUT - 1)) begin
                    init_fail = 1'b1;
                    init_code = 3'd4;
                end
            end
            default: ;
        endcase
    end

    // init FSM; S_DONE and S_FAIL hold until reset
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state    <= S_NOP;
            nop_cnt  <= '0;
            ref_cnt  <= '0;
            done_cnt <= '0;
            init_ok  <= 1'b0;
        end else if (init_fail) begin
            state <= S_FAIL;
        end else begin
            unique case (state)
                S_NOP: begin
                    if (nop_cnt >= NOP_W'(INIT_NOP_CYCLES - 1))
                        state <= S_PRE;
                    else
                        nop_cnt <= nop_cnt + NOP_W'(1);
                end
                S_PRE: begin
                    if (is_pre)
                        state <= S_REF;
                end
                S_REF: begin
                    if (is_ref && !ref_full)
                        ref_cnt <= ref_cnt + REF_W'(1);
                    if (is_lmr)
                        state <= S_WDONE;
                end
                S_WDONE: begin
                    if (sdr_init_done) begin
                        state   <= S_DONE;
                        init_ok <= 1'b1;
                    end else begin
                        done_cnt <= done_cnt + DONE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // rd_pipe[k] is set when a READ was issued k cycles ago (bit 0 = now)
    logic [MAX_CAS-1:0] rd_sr;
    logic [MAX_CAS:0]   rd_pipe;
    logic [1:0]         cas_q;
    logic [SUP_W-1:0]   sup_cnt;
    logic cas_chg, cas_en, cas_tap, cas_viol;

    assign rd_pipe = {rd_sr, is_read & (state == S_DONE)};
    assign cas_chg = cfg_sdr_cas != cas_q;
    assign cas_en  = (state == S_DONE) && (sup_cnt == '0) && !cas_chg &&
                     (cfg_sdr_cas != 2'd0) && (int'(cfg_sdr_cas) <= MAX_CAS);

    // select the pipeline tap matching the configured latency
    always_comb begin
        cas_tap = 1'b0;
        for (int k = 1; k <= MAX_CAS; k++)
            if (int'(cfg_sdr_cas) == k)
                cas_tap = rd_pipe[k];
    end

    assign cas_viol = cas_en & cas_tap & !dataout_en;

    // read history; a latency change flushes it and mutes checks briefly
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            rd_sr   <= '0;
            cas_q   <= 2'd0;
            sup_cnt <= '0;
        end else if (cas_chg) begin
            rd_sr   <= '0;
            cas_q   <= cfg_sdr_cas;
            sup_cnt <= SUP_W'(MAX_CAS + 1);
        end else begin
            rd_sr <= rd_pipe[MAX_CAS-1:0];
            if (sup_cnt != '0)
                sup_cnt <= sup_cnt - SUP_W'(1);
        end
    end

    logic wb_viol_proto, wb_viol_to;

`ifdef SDRAM_MON_WB_CHECK_EN
    localparam int WB_W = $clog2(WB_ACK_TIMEOUT + 1);
    logic [WB_W-1:0] wb_cnt;

    assign wb_viol_proto = (wb_stb_i & !wb_cyc_i) |
                           (wb_ack_i & !(wb_cyc_i & wb_stb_i));
    assign wb_viol_to    = wb_cyc_i & wb_stb_i & !wb_ack_i &
                           (wb_cnt == WB_W'(WB_ACK_TIMEOUT - 1));

    // ack wait counter; parks at the limit so a stall is reported once
    always_ff @(posedge sys_clk) begin
        if (!reset_n)
            wb_cnt <= '0;
        else if (wb_ack_i || !wb_cyc_i)
            wb_cnt <= '0;
        else if (wb_stb_i && wb_cnt != WB_W'(WB_ACK_TIMEOUT))
            wb_cnt <= wb_cnt + WB_W'(1);
    end
`else
    logic unused_wb;
    assign unused_wb     = wb_cyc_i ^ wb_stb_i ^ wb_ack_i;
    assign wb_viol_proto = 1'b0;
    assign wb_viol_to    = 1'b0;
`endif

    logic       any_viol;
    logic [2:0] viol_code;

    // lowest-numbered cause wins when several fire in one cycle
    always_comb begin
        any_viol  = init_fail | cas_viol | wb_viol_proto | wb_viol_to;
        viol_code = 3'd0;
        if (init_fail)
            viol_code = init_code;
        else if (cas_viol)
            viol_code = 3'd5;
        else if (wb_viol_proto)
            viol_code = 3'd6;
        else if (wb_viol_to)
            viol_code = 3'd7;
    end

    // sticky flags, first-error code and saturating violation count
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            err_init  <= 1'b0;
            err_cas   <= 1'b0;
            err_wb    <= 1'b0;
            err_code  <= 3'd0;
            err_count <= '0;
        end else begin
            if (init_fail)
                err_init <= 1'b1;
            if (cas_viol)
                err_cas <= 1'b1;
            if (wb_viol_proto || wb_viol_to)
                err_wb <= 1'b1;
            if (any_viol && err_code == 3'd0)
                err_code <= viol_code;
            if (any_viol && err_count != '1)
                err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sdram_protocol_monitor.sv
// Scoreboard bench for sdram_protocol_monitor.
// Expected output snapshots are queued by stimulus and checked by a monitor.
module tb_sdram_protocol_monitor;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sdr_cs_n = 1'b0, sdr_ras_n = 1'b1;
    logic       sdr_cas_n = 1'b1, sdr_we_n = 1'b1;
    logic       dataout_en = 1'b0;
    logic [1:0] cfg_sdr_cas = 2'd3;
    logic       sdr_init_done = 1'b0;
    logic       wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_ack_i = 1'b0;
    logic       init_ok, err_init, err_cas, err_wb;
    logic [2:0] err_code;
    logic [7:0] err_count;

    int n_chk  = 0;
    int n_pass = 0;

    string       name_q[$];
    logic [14:0] exp_q[$];

    sdram_protocol_monitor dut (
        .sys_clk       (sys_clk),
        .reset_n       (reset_n),
        .sdr_cs_n      (sdr_cs_n),
        .sdr_ras_n     (sdr_ras_n),
        .sdr_cas_n     (sdr_cas_n),
        .sdr_we_n      (sdr_we_n),
        .dataout_en    (dataout_en),
        .cfg_sdr_cas   (cfg_sdr_cas),
        .sdr_init_done (sdr_init_done),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_ack_i      (wb_ack_i),
        .init_ok       (init_ok),
        .err_init      (err_init),
        .err_cas       (err_cas),
        .err_wb        (err_wb),
        .err_code      (err_code),
        .err_count     (err_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input logic [3:0] c, input logic de = 1'b0);
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
        dataout_en = de;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sdr_init_done = 1'b0;
        {wb_cyc_i, wb_stb_i, wb_ack_i} = 3'b000;
        tick(C_NOP);
        reset_n = 1'b1;
    endtask

    task automatic expect_out(input string nm, input logic ok,
                              input logic ei, input logic ec,
                              input logic ew, input logic [2:0] code,
                              input logic [7:0] cnt);
        name_q.push_back(nm);
        exp_q.push_back({ok, ei, ec, ew, code, cnt});
    endtask

    task automatic init_seq(input int nref, input int done_dly);
        repeat (10000) tick(C_NOP);
        tick(C_PRE);
        repeat (nref) begin
            tick(C_REF);
            repeat (9) tick(C_NOP);
        end
        tick(C_LMR);
        if (done_dly > 0) begin
            repeat (done_dly - 1) tick(C_NOP);
            sdr_init_done = 1'b1;
            tick(C_NOP);
        end
    endtask

    // monitor: compare every queued snapshot against the settled outputs
    initial begin
        logic [14:0] e, a;
        string nm;
        forever begin
            @(negedge sys_clk);
            while (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {init_ok, err_init, err_cas, err_wb, err_code, err_count};
                n_chk++;
                if (a === e)
                    n_pass++;
                else
                    $display("FAIL %s: got ok=%0b init=%0b cas=%0b wb=%0b code=%0d cnt=%0d required ok=%0b init=%0b cas=%0b wb=%0b code=%0d cnt=%0d",
                             nm, a[14], a[13], a[12], a[11], a[10:8], a[7:0],
                             e[14], e[13], e[12], e[11], e[10:8], e[7:0]);
            end
        end
    end

    initial begin
        repeat (150000) @(posedge sys_clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        expect_out("reset_state", 0, 0, 0, 0, 3'd0, 8'd0);

        // clean init
        init_seq(16, 18);
        expect_out("clean_init", 1, 0, 0, 0, 3'd0, 8'd0);

        // CL=3 read with burst data at +3/+4
        tick(C_RD);
        tick(C_NOP);
        tick(C_NOP);
        tick(C_NOP, 1'b1);
        tick(C_NOP, 1'b1);
        repeat (3) tick(C_NOP);
        expect_out("cl3_ok", 1, 0, 0, 0, 3'd0, 8'd0);

        // CL=2, data late at +3
        cfg_sdr_cas = 2'd2;
        repeat (8) tick(C_NOP);
        tick(C_RD);
        tick(C_NOP);
        tick(C_NOP);
        expect_out("cl2_late", 1, 0, 1, 0, 3'd5, 8'd1);
        tick(C_NOP, 1'b1);
        repeat (3) tick(C_NOP);

        // CL=2, data on time
        tick(C_RD);
        tick(C_NOP);
        tick(C_NOP, 1'b1);
        repeat (3) tick(C_NOP);
        expect_out("cl2_ok", 1, 0, 1, 0, 3'd5, 8'd1);

        // change to CL=1: read right after the change is muted
        cfg_sdr_cas = 2'd1;
        tick(C_NOP);
        tick(C_RD);
        repeat (8) tick(C_NOP);
        expect_out("cl_change_mute", 1, 0, 1, 0, 3'd5, 8'd1);

        // CL=1 read without data
        tick(C_RD);
        tick(C_NOP);
        expect_out("cl1_missing", 1, 0, 1, 0, 3'd5, 8'd2);

        // CL=0 disables checking
        cfg_sdr_cas = 2'd0;
        repeat (8) tick(C_NOP);
        tick(C_RD);
        repeat (5) tick(C_NOP);
        expect_out("cl0_disabled", 1, 0, 1, 0, 3'd5, 8'd2);
        cfg_sdr_cas = 2'd3;

        // early ACTIVE during NOP window
        do_reset();
        repeat (500) tick(C_NOP);
        tick(C_ACT);
        expect_out("early_active", 0, 1, 0, 0, 3'd1, 8'd1);
        tick(C_PRE);
        tick(C_REF);
        tick(C_LMR);
        sdr_init_done = 1'b1;
        repeat (3) tick(C_NOP);
        expect_out("fail_terminal", 0, 1, 0, 0, 3'd1, 8'd1);

        // 15 refreshes then LMR
        do_reset();
        expect_out("reset_after_fail", 0, 0, 0, 0, 3'd0, 8'd0);
        init_seq(15, 0);
        expect_out("short_refresh", 0, 1, 0, 0, 3'd3, 8'd1);

        // init_done never arrives
        do_reset();
        init_seq(16, 0);
        repeat (31) tick(C_NOP);
        expect_out("done_wait_edge", 0, 0, 0, 0, 3'd0, 8'd0);
        tick(C_NOP);
        expect_out("done_timeout", 0, 1, 0, 0, 3'd4, 8'd1);

        // init_done during NOP window
        do_reset();
        repeat (5) tick(C_NOP);
        sdr_init_done = 1'b1;
        tick(C_NOP);
        expect_out("early_done", 0, 1, 0, 0, 3'd3, 8'd1);

        // reset mid-REF aborts, then clean init
        do_reset();
        repeat (10000) tick(C_NOP);
        tick(C_PRE);
        repeat (5) begin
            tick(C_REF);
            repeat (9) tick(C_NOP);
        end
        do_reset();
        expect_out("mid_ref_reset", 0, 0, 0, 0, 3'd0, 8'd0);
        init_seq(16, 18);
        expect_out("reinit_ok", 1, 0, 0, 0, 3'd0, 8'd0);

        // Wishbone stall and stray ack
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        repeat (63) tick(C_NOP);
        expect_out("wb_wait_edge", 1, 0, 0, 0, 3'd0, 8'd0);
        tick(C_NOP);
`ifdef SDRAM_MON_WB_CHECK_EN
        expect_out("wb_timeout", 1, 0, 0, 1, 3'd7, 8'd1);
`else
        expect_out("wb_timeout", 1, 0, 0, 0, 3'd0, 8'd0);
`endif
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        tick(C_NOP);
        wb_ack_i = 1'b1;
        tick(C_NOP);
        wb_ack_i = 1'b0;
`ifdef SDRAM_MON_WB_CHECK_EN
        expect_out("wb_stray_ack", 1, 0, 0, 1, 3'd7, 8'd2);
`else
        expect_out("wb_stray_ack", 1, 0, 0, 0, 3'd0, 8'd0);
`endif

        // stray ack as first error
        do_reset();
        wb_ack_i = 1'b1;
        tick(C_NOP);
        wb_ack_i = 1'b0;
        wb_stb_i = 1'b1;
        tick(C_NOP);
        wb_stb_i = 1'b0;
`ifdef SDRAM_MON_WB_CHECK_EN
        expect_out("wb_ack_first", 0, 0, 0, 1, 3'd6, 8'd2);
`else
        expect_out("wb_ack_first", 0, 0, 0, 0, 3'd0, 8'd0);
`endif

        repeat (3) tick(C_NOP);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending snapshots required 0",
                     exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
